// File: rtl/countdown_pkg.sv
// countdown_timer shared types and constants.
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Prescaler counter width, never below 1 bit.
  function automatic int psw(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

  localparam int PRESCALE_DEF = 1;
  localparam int PSW_DEF      = psw(PRESCALE_DEF);

endpackage

// File: rtl/countdown_timer_tick_div.sv
// Prescaler: one tick every PRESCALE enabled cycles.
// With PRESCALE=1 the counter stays at 0 and tick follows en.
module tick_div
  import countdown_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = psw(PRESCALE);
  localparam logic [PW-1:0] TOP = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  assign tick = en && (cnt == TOP);

  // Advance on enable, wrap on tick, clear on request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + PW'(1);
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counting timer with one-cycle done pulse.
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN (periodic mode).
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] v,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  state_t           state, state_n;
  logic [WIDTH-1:0] count_n;
  logic             done_n;
  logic             tick;
  logic             accept;

  assign accept = start && (state == IDLE) && !abort;

  tick_div #(
    .PRESCALE(PRESCALE)
  ) u_div (
    .clk (clk),
    .rst (rst),
    .clr ((state != RUN) || abort),
    .en  (en && (state == RUN)),
    .tick(tick)
  );

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload;

  // Capture the period on every accepted load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reload <= '0;
    end else if (accept) begin
      reload <= v;
    end
  end
`endif

  // Next state, next count and expiry pulse.
  always_comb begin
    state_n = state;
    count_n = count;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          count_n = v;
          if (v == '0) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
          count_n = '0;
        end else if (tick) begin
          if (count == WIDTH'(1)) begin
            done_n = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            count_n = reload;
`else
            count_n = '0;
            state_n = DONE;
`endif
          end else if (count != '0) begin
            count_n = count - WIDTH'(1);
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        if (abort) begin
          count_n = '0;
        end
      end
      default: begin
        state_n = IDLE;
        count_n = '0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
      ready <= 1'b1;
    end else begin
      state <= state_n;
      count <= count_n;
      done  <= done_n;
      busy  <= (state_n == RUN);
      ready <= (state_n == IDLE);
    end
  end

endmodule
